// File: rtl/avalon_mem_arbiter_if.sv
// Avalon-MM port bundle: one command/response channel between a master and a slave.
interface avalon_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W-1:0]   writedata;
  logic [DATA_W/8-1:0] byteenable;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/avalon_mem_arbiter.sv
// Two-master round-robin arbiter in front of a single Avalon-MM RAM port.
// One transfer per grant, always followed by an IDLE cycle. A granted transfer
// that stalls too long on the RAM is aborted with ERR_DATA and a sticky bus_error.
module avalon_mem_arbiter #(
  parameter int              ADDR_W   = 32,
  parameter int              DATA_W   = 32,
  parameter int              TIMEOUT  = 1023,
  parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEADBEEF)
) (
  input  logic                 clk,
  input  logic                 reset,
  avalon_mem_arbiter_if.slave  m0,
  avalon_mem_arbiter_if.slave  m1,
  avalon_mem_arbiter_if.master s,
  output logic                 bus_error
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t             state, state_nxt;
  logic               last, last_nxt;
  logic [CNT_W-1:0]   stall_cnt, stall_nxt;
  logic               bus_error_nxt;

  logic               req0, req1;
  logic               gsel, granted, abort;
  logic               g_read, g_write, g_req;
  logic [ADDR_W-1:0]  g_addr;
  logic [DATA_W-1:0]  g_wdata;
  logic [DATA_W/8-1:0] g_be;

  assign req0    = m0.read | m0.write;
  assign req1    = m1.read | m1.write;
  assign gsel    = (state == GRANT1);
  assign granted = (state != IDLE) && !reset;

  // Command mux from whichever master currently owns the bus.
  assign g_read  = gsel ? m1.read       : m0.read;
  assign g_write = gsel ? m1.write      : m0.write;
  assign g_addr  = gsel ? m1.address    : m0.address;
  assign g_wdata = gsel ? m1.writedata  : m0.writedata;
  assign g_be    = gsel ? m1.byteenable : m0.byteenable;
  assign g_req   = g_read | g_write;

  // Last permitted stall cycle: abort instead of waiting again.
  assign abort = granted && g_req && s.waitrequest &&
                 (stall_cnt == CNT_W'(TIMEOUT - 1));

  // State, round-robin pointer, stall counter and sticky error.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      stall_cnt <= '0;
      bus_error <= 1'b0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      stall_cnt <= stall_nxt;
      bus_error <= bus_error_nxt;
    end
  end

  // Next-state: grant on request, release on completion, drop or timeout.
  always_comb begin
    state_nxt     = state;
    last_nxt      = last;
    stall_nxt     = '0;
    bus_error_nxt = bus_error;
    case (state)
      IDLE: begin
        if (req0 && req1)  state_nxt = last ? GRANT0 : GRANT1;
        else if (req0)     state_nxt = GRANT0;
        else if (req1)     state_nxt = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (!g_req) begin
          state_nxt = IDLE;
        end else if (!s.waitrequest) begin
          state_nxt = IDLE;
          last_nxt  = gsel;
        end else if (abort) begin
          state_nxt     = IDLE;
          last_nxt      = gsel;
          bus_error_nxt = 1'b1;
        end else begin
          stall_nxt = stall_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Bus outputs: forward the owner's command, park everything else.
  // Write wins over read; an aborted transfer is withdrawn from the RAM.
  always_comb begin
    s.address      = '0;
    s.read         = 1'b0;
    s.write        = 1'b0;
    s.writedata    = '0;
    s.byteenable   = '0;
    m0.waitrequest = 1'b1;
    m0.readdata    = '0;
    m1.waitrequest = 1'b1;
    m1.readdata    = '0;
    if (granted) begin
      s.address    = g_addr;
      s.writedata  = g_wdata;
      s.byteenable = g_be;
      s.write      = g_write & ~abort;
      s.read       = g_read & ~g_write & ~abort;
      if (gsel) begin
        m1.waitrequest = abort ? 1'b0 : s.waitrequest;
        m1.readdata    = abort ? ERR_DATA : s.readdata;
      end else begin
        m0.waitrequest = abort ? 1'b0 : s.waitrequest;
        m0.readdata    = abort ? ERR_DATA : s.readdata;
      end
    end
  end

endmodule

// File: tb/tb_avalon_mem_arbiter.sv
// Bench for avalon_mem_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_avalon_mem_arbiter;

  localparam int TO = 4;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bus_error;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  avalon_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m0_bus ();
  avalon_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) m1_bus ();
  avalon_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) s_bus ();

  avalon_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
    .clk       (clk),
    .reset     (rst),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .s         (s_bus),
    .bus_error (bus_error)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- transaction-level model ----------------
  // owner: -1 = bus free, else index of the master holding the current grant.
  int   owner = -1;
  int   last_srv = 1;
  int   waited = 0;
  bit   err = 1'b0;
  bit   mdl_ok = 1'b0;

  logic [31:0] ma [2];
  logic [31:0] md [2];
  logic [3:0]  mb [2];
  bit          mr [2];
  bit          mw [2];
  bit          rq [2];
  logic [31:0] e_addr, e_wd;
  logic [3:0]  e_be;
  bit          e_rd, e_wr, ab;
  bit          e_w [2];
  logic [31:0] e_d [2];

  // Compare every cycle on the falling edge, then advance the model past the next rising edge.
  always @(negedge clk) begin
    ma[0] = m0_bus.address; md[0] = m0_bus.writedata; mb[0] = m0_bus.byteenable;
    mr[0] = m0_bus.read;    mw[0] = m0_bus.write;
    ma[1] = m1_bus.address; md[1] = m1_bus.writedata; mb[1] = m1_bus.byteenable;
    mr[1] = m1_bus.read;    mw[1] = m1_bus.write;
    rq[0] = mr[0] | mw[0];
    rq[1] = mr[1] | mw[1];

    e_addr = '0; e_wd = '0; e_be = '0; e_rd = 0; e_wr = 0; ab = 0;
    e_w[0] = 1; e_w[1] = 1; e_d[0] = '0; e_d[1] = '0;
    if (!rst && mdl_ok && owner >= 0) begin
      ab     = rq[owner] && s_bus.waitrequest && (waited == TO - 1);
      e_addr = ma[owner];
      e_wd   = md[owner];
      e_be   = mb[owner];
      e_wr   = mw[owner] && !ab;
      e_rd   = mr[owner] && !mw[owner] && !ab;
      e_w[owner] = ab ? 1'b0 : s_bus.waitrequest;
      e_d[owner] = ab ? ERR : s_bus.readdata;
    end

    if (rst || mdl_ok) begin
      check("s_address",    s_bus.address,     e_addr);
      check("s_read",       s_bus.read,        e_rd);
      check("s_write",      s_bus.write,       e_wr);
      check("s_writedata",  s_bus.writedata,   e_wd);
      check("s_byteenable", s_bus.byteenable,  e_be);
      check("m0_waitreq",   m0_bus.waitrequest, e_w[0]);
      check("m0_readdata",  m0_bus.readdata,   e_d[0]);
      check("m1_waitreq",   m1_bus.waitrequest, e_w[1]);
      check("m1_readdata",  m1_bus.readdata,   e_d[1]);
    end
    if (mdl_ok) check("bus_error", bus_error, err);

    if (rst) begin
      owner = -1; last_srv = 1; waited = 0; err = 0; mdl_ok = 1;
    end else if (mdl_ok) begin
      if (owner < 0) begin
        waited = 0;
        if (rq[0] && rq[1]) owner = 1 - last_srv;
        else if (rq[0])     owner = 0;
        else if (rq[1])     owner = 1;
      end else if (!rq[owner]) begin
        owner = -1; waited = 0;
      end else if (!s_bus.waitrequest) begin
        last_srv = owner; owner = -1; waited = 0;
      end else if (ab) begin
        last_srv = owner; owner = -1; waited = 0; err = 1;
      end else begin
        waited++;
      end
    end
  end

  // ---------------- stimulus ----------------
  int          wins [$];
  int          cnt_a, cnt_b;
  logic [31:0] cap;
  int          mode;

  initial begin
    m0_bus.address = '0; m0_bus.read = 0; m0_bus.write = 0; m0_bus.writedata = '0; m0_bus.byteenable = '0;
    m1_bus.address = '0; m1_bus.read = 0; m1_bus.write = 0; m1_bus.writedata = '0; m1_bus.byteenable = '0;
    s_bus.waitrequest = 1'b0; s_bus.readdata = '0;

    // Reset state.
    step(); step(); #2;
    check("rst_s_read",  s_bus.read,         0);
    check("rst_m0_wait", m0_bus.waitrequest, 1);
    check("rst_m1_wait", m1_bus.waitrequest, 1);

    // 1: m1 read 0x04, RAM ready -> granted one cycle later, single-cycle completion.
    step(); rst = 0;
    m1_bus.address = 32'h4; m1_bus.read = 1; m1_bus.byteenable = 4'hF;
    s_bus.waitrequest = 0; s_bus.readdata = 32'h11223344;
    #2; check("t1_wait_in_idle", m1_bus.waitrequest, 1);
    step(); #2;
    check("t1_s_read",  s_bus.read,        1);
    check("t1_s_addr",  s_bus.address,     32'h4);
    check("t1_m1_wait", m1_bus.waitrequest, 0);
    check("t1_m1_data", m1_bus.readdata,   32'h11223344);
    step(); m1_bus.read = 0;

    // 2: simultaneous requests from reset -> m0 first, then strict alternation.
    rst = 1; step(); rst = 0;
    m0_bus.address = 32'h10; m0_bus.read = 1;
    m1_bus.address = 32'h20; m1_bus.read = 1;
    wins.delete();
    for (int c = 0; c < 8; c++) begin
      step(); #2;
      if (m0_bus.waitrequest === 1'b0) wins.push_back(0);
      if (m1_bus.waitrequest === 1'b0) wins.push_back(1);
    end
    check("t2_grants", wins.size(), 4);
    for (int i = 0; i < wins.size() && i < 4; i++) check("t2_order", wins[i], i % 2);
    m0_bus.read = 0;

    // 3: m1 alone, held -> served every second cycle, m0 never released.
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 8; c++) begin
      step(); #2;
      if (m0_bus.waitrequest !== 1'b1) cnt_a++;
      if (m1_bus.waitrequest === 1'b0) cnt_b++;
    end
    check("t3_m0_released", cnt_a, 0);
    check("t3_m1_served",   cnt_b, 4);
    m1_bus.read = 0;
    step();

    // 4: m0 write stalled 3 cycles (completes on the last allowed stall count).
    m0_bus.address = 32'h4; m0_bus.write = 1; m0_bus.writedata = 32'h24020010; m0_bus.byteenable = 4'hF;
    s_bus.waitrequest = 1;
    cnt_a = 0; cnt_b = 0; cap = '0;
    for (int c = 0; c < 4; c++) begin
      step(); s_bus.waitrequest = (c == 3) ? 1'b0 : 1'b1; #2;
      if (s_bus.write && m0_bus.waitrequest) cnt_a++;
      if (s_bus.write && !s_bus.waitrequest) begin cnt_b++; cap = s_bus.writedata; end
    end
    check("t4_stalls",   cnt_a, 3);
    check("t4_accepts",  cnt_b, 1);
    check("t4_wdata",    cap,   32'h24020010);
    step(); m0_bus.write = 0; #2;
    check("t4_no_error", bus_error, 0);

    // 5: RAM stuck -> m1 read aborted with ERR_DATA, bus_error set.
    m1_bus.address = 32'h8; m1_bus.read = 1; s_bus.waitrequest = 1;
    for (int c = 0; c < 4; c++) begin
      step(); #2;
      if (c < 3) begin
        check("t5_stall_wait",  m1_bus.waitrequest, 1);
        check("t5_stall_read",  s_bus.read,         1);
      end else begin
        check("t5_abort_wait",  m1_bus.waitrequest, 0);
        check("t5_abort_data",  m1_bus.readdata,    ERR);
        check("t5_abort_sread", s_bus.read,         0);
      end
    end
    step(); m1_bus.read = 0; #2;
    check("t5_bus_error", bus_error, 1);

    // 6: reset while m1 stalls in grant -> command drops, error cleared.
    m1_bus.read = 1;
    step(); step();
    rst = 1;
    step(); #2;
    check("t6_s_read",    s_bus.read,         0);
    check("t6_m0_wait",   m0_bus.waitrequest, 1);
    check("t6_m1_wait",   m1_bus.waitrequest, 1);
    check("t6_bus_error", bus_error,          0);
    rst = 0; m1_bus.read = 0;

    // Randomized traffic; the model checks every cycle.
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      step();
      if (c % 100 == 0) mode = $urandom_range(0, 2);
      rst = ($urandom_range(0, 299) == 0);
      m0_bus.read  = ($urandom_range(0, 2) == 0);
      m0_bus.write = ($urandom_range(0, 3) == 0);
      m1_bus.read  = ($urandom_range(0, 1) == 0);
      m1_bus.write = ($urandom_range(0, 4) == 0);
      m0_bus.address = $urandom; m0_bus.writedata = $urandom; m0_bus.byteenable = 4'($urandom);
      m1_bus.address = $urandom; m1_bus.writedata = $urandom; m1_bus.byteenable = 4'($urandom);
      case (mode)
        0:       s_bus.waitrequest = ($urandom_range(0, 3) == 0);
        1:       s_bus.waitrequest = ($urandom_range(0, 7) != 0);
        default: s_bus.waitrequest = ($urandom_range(0, 1) == 0);
      endcase
      s_bus.readdata = $urandom;
    end
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
